interleaved_fifo_bank_ctrl: RTL and testbench

//  Controller for a synchronous FIFO built from two single-port RAM banks (even/odd entries).

---
 rtl/interleaved_fifo_bank_ctrl_if.sv | 26 ++
 rtl/interleaved_fifo_bank_ctrl.sv | 141 ++++++++++++++
 tb/tb_interleaved_fifo_bank_ctrl.sv | 380 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/interleaved_fifo_bank_ctrl_if.sv
// Stream-side bundle of the interleaved FIFO controller: write stream,
// read stream and the occupancy count.
interface interleaved_fifo_bank_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 512
);
    logic [DATA_WIDTH-1:0]      s_data;
    logic                       s_valid;
    logic                       s_ready;
    logic [DATA_WIDTH-1:0]      m_data;
    logic                       m_valid;
    logic                       m_ready;
    logic [$clog2(DEPTH+1)-1:0] count;

    // Controller side
    modport slave (
        input  s_data, s_valid, m_ready,
        output s_ready, m_data, m_valid, count
    );

    // Producer/consumer side
    modport master (
        output s_data, s_valid, m_ready,
        input  s_ready, m_data, m_valid, count
    );
endinterface

// File: rtl/interleaved_fifo_bank_ctrl.sv
// Controller for a FIFO stored in two single-port RAM banks (even/odd
// entries). Entry k lives in bank k[0] at address k>>1. Reads go through a
// two-stage latency pipeline into a 4-entry output skid buffer.
module interleaved_fifo_bank_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 512,
    parameter int OUT_DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rstn,
    interleaved_fifo_bank_ctrl_if.slave  bus,
    output logic [DATA_WIDTH-1:0]        bank0_din,
    output logic [$clog2(DEPTH/2)-1:0]   bank0_addr,
    output logic                         bank0_wr_en,
    input  logic [DATA_WIDTH-1:0]        bank0_dout,
    output logic [DATA_WIDTH-1:0]        bank1_din,
    output logic [$clog2(DEPTH/2)-1:0]   bank1_addr,
    output logic                         bank1_wr_en,
    input  logic [DATA_WIDTH-1:0]        bank1_dout
);
    localparam int PW = $clog2(DEPTH);
    localparam int AW = $clog2(DEPTH/2);
    localparam int CW = $clog2(DEPTH+1);

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         ram_cnt;
    logic [CW-1:0]         cnt;
    logic                  vld_p1;
    logic                  vld_p2;
    logic                  bank_p1;
    logic                  bank_p2;
    logic [2:0]            out_cnt;
    logic [1:0]            ob_head;
    logic [1:0]            ob_tail;
    logic [DATA_WIDTH-1:0] obuf [OUT_DEPTH];
    logic [AW-1:0]         addr0_q;
    logic [AW-1:0]         addr1_q;

    logic                  wr_acc;
    logic                  pop;
    logic                  rd_go;
    logic                  wr_conflict;
    logic [2:0]            inflight;
    logic [DATA_WIDTH-1:0] push_data;

    // Handshakes; s_ready is forced low while reset is asserted
    assign bus.s_ready = rstn & (cnt < CW'(DEPTH));
    assign bus.m_valid = (out_cnt != 3'd0);
    assign bus.m_data  = obuf[ob_head];
    assign bus.count   = cnt;

    assign wr_acc      = bus.s_valid & bus.s_ready;
    assign pop         = bus.m_valid & bus.m_ready;

    // Output slots already spoken for: buffered words plus both pipeline stages
    assign inflight    = out_cnt + {2'b00, vld_p1} + {2'b00, vld_p2};
    // A write to the bank the read wants wins; the read retries next cycle
    assign wr_conflict = wr_acc & (wr_ptr[0] == rd_ptr[0]);
    assign rd_go       = (ram_cnt != '0) & (inflight < 3'(OUT_DEPTH)) & ~wr_conflict;

    assign push_data   = bank_p2 ? bank1_dout : bank0_dout;

    // Per-bank port drive: write, read, or hold the previous address when idle
    always_comb begin
        bank0_wr_en = 1'b0;
        bank1_wr_en = 1'b0;
        bank0_din   = bus.s_data;
        bank1_din   = bus.s_data;
        bank0_addr  = addr0_q;
        bank1_addr  = addr1_q;
        if (rd_go) begin
            if (rd_ptr[0]) bank1_addr = rd_ptr[PW-1:1];
            else           bank0_addr = rd_ptr[PW-1:1];
        end
        if (wr_acc) begin
            if (wr_ptr[0]) begin
                bank1_wr_en = 1'b1;
                bank1_addr  = wr_ptr[PW-1:1];
            end else begin
                bank0_wr_en = 1'b1;
                bank0_addr  = wr_ptr[PW-1:1];
            end
        end
    end

    // Remember the last address driven on each bank so idle cycles hold it
    always_ff @(posedge clk) begin
        addr0_q <= bank0_addr;
        addr1_q <= bank1_addr;
    end

    // Pointers and occupancy counters
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ram_cnt <= '0;
            cnt     <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_go)  rd_ptr <= rd_ptr + 1'b1;
            ram_cnt <= ram_cnt + CW'(wr_acc) - CW'(rd_go);
            cnt     <= cnt + CW'(wr_acc) - CW'(pop);
        end
    end

    // Stage p1: read address presented to the RAM
    // Stage p2: RAM data lands on bankN_dout and is captured on this edge
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_p1  <= 1'b0;
            bank_p1 <= 1'b0;
            vld_p2  <= 1'b0;
            bank_p2 <= 1'b0;
        end else begin
            vld_p1  <= rd_go;
            bank_p1 <= rd_ptr[0];
            vld_p2  <= vld_p1;
            bank_p2 <= bank_p1;
        end
    end

    // Output skid buffer control: circular head/tail and fill level
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ob_head <= '0;
            ob_tail <= '0;
            out_cnt <= '0;
        end else begin
            if (vld_p2) ob_tail <= ob_tail + 1'b1;
            if (pop)    ob_head <= ob_head + 1'b1;
            out_cnt <= out_cnt + {2'b00, vld_p2} - {2'b00, pop};
        end
    end

    // Output skid buffer storage; space was reserved when the read issued
    always_ff @(posedge clk) begin
        if (vld_p2) obuf[ob_tail] <= push_data;
    end
endmodule

// File: tb/tb_interleaved_fifo_bank_ctrl.sv
// Testbench for interleaved_fifo_bank_ctrl: two behavioural 2-cycle-latency
// RAM banks plus a queue-based reference FIFO.
module tb_interleaved_fifo_bank_ctrl;
    localparam int DW    = 8;
    localparam int DEPTH = 512;
    localparam int AW    = $clog2(DEPTH/2);
    localparam int CW    = $clog2(DEPTH+1);

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    interleaved_fifo_bank_ctrl_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    logic [DW-1:0] b0_din, b1_din, b0_dout, b1_dout;
    logic [AW-1:0] b0_addr, b1_addr;
    logic          b0_we, b1_we;

    interleaved_fifo_bank_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .OUT_DEPTH(4)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .bus         (bus),
        .bank0_din   (b0_din),
        .bank0_addr  (b0_addr),
        .bank0_wr_en (b0_we),
        .bank0_dout  (b0_dout),
        .bank1_din   (b1_din),
        .bank1_addr  (b1_addr),
        .bank1_wr_en (b1_we),
        .bank1_dout  (b1_dout)
    );

    // Single-port RAM models with registered output (2-cycle read latency)
    logic [DW-1:0] mem0 [DEPTH/2];
    logic [DW-1:0] mem1 [DEPTH/2];
    logic [DW-1:0] r0_s1, r1_s1;
    always_ff @(posedge clk) begin
        if (b0_we) mem0[b0_addr] <= b0_din;
        if (b1_we) mem1[b1_addr] <= b1_din;
        r0_s1   <= mem0[b0_addr];
        r1_s1   <= mem1[b1_addr];
        b0_dout <= r0_s1;
        b1_dout <= r1_s1;
    end

    // Reference model
    logic [DW-1:0] sb_q [$];
    int exp_cnt  = 0;
    int exp_wptr = 0;

    int checks = 0;
    int errors = 0;

    // Observations of one cycle
    logic          o_sr, o_mv, o_acc, o_pop;
    logic [DW-1:0] o_md, o_exp_md, o_b0d, o_b1d;
    logic [CW-1:0] o_cnt;
    logic          o_b0we, o_b1we;
    logic [AW-1:0] o_b0a, o_b1a;
    int            o_exp_cnt, o_exp_wptr;

    // Drive one cycle, sample at the falling edge, advance the reference model
    task automatic do_cycle(input logic sv, input logic [DW-1:0] sd, input logic mr);
        bus.s_valid = sv;
        bus.s_data  = sd;
        bus.m_ready = mr;
        @(negedge clk);
        o_sr   = bus.s_ready;
        o_mv   = bus.m_valid;
        o_md   = bus.m_data;
        o_cnt  = bus.count;
        o_b0we = b0_we;  o_b0a = b0_addr;  o_b0d = b0_din;
        o_b1we = b1_we;  o_b1a = b1_addr;  o_b1d = b1_din;
        o_acc  = sv & o_sr;
        o_pop  = o_mv & mr;
        o_exp_cnt  = exp_cnt;
        o_exp_wptr = exp_wptr;
        o_exp_md   = 'x;
        if (o_pop && sb_q.size() > 0) o_exp_md = sb_q.pop_front();
        if (o_acc) begin
            sb_q.push_back(sd);
            exp_wptr = (exp_wptr + 1) % DEPTH;
        end
        exp_cnt = exp_cnt + int'(o_acc) - int'(o_pop);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h11;
        bus.m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.m_valid !== 1'b0 || bus.s_ready !== 1'b0 || bus.count !== '0) begin
            errors++;
            $display("FAIL reset_outputs: m_valid=%b s_ready=%b count=%0d, required 0 0 0",
                     bus.m_valid, bus.s_ready, bus.count);
        end
        checks++;
        if (b0_we !== 1'b0 || b1_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_wr_en: bank0=%b bank1=%b, required 0 0", b0_we, b1_we);
        end
        bus.s_valid = 1'b0;
        rstn = 1'b1;
        do_cycle(1'b0, '0, 1'b1);
        checks++;
        if (o_cnt !== '0 || o_sr !== 1'b1 || o_mv !== 1'b0) begin
            errors++;
            $display("FAIL after_reset: count=%0d s_ready=%b m_valid=%b, required 0 1 0",
                     o_cnt, o_sr, o_mv);
        end
    endtask

    task automatic test_single;
        do_cycle(1'b1, 8'hA5, 1'b1);
        checks++;
        if (o_b0we !== 1'b1 || o_b0a !== '0 || o_b0d !== 8'hA5 || o_b1we !== 1'b0) begin
            errors++;
            $display("FAIL single_write_port: b0we=%b addr=%0d din=%h b1we=%b, required 1 0 a5 0",
                     o_b0we, o_b0a, o_b0d, o_b1we);
        end
        for (int c = 1; c <= 4; c++) begin
            do_cycle(1'b0, '0, 1'b1);
            if (c == 1) begin
                checks++;
                if (o_cnt !== CW'(1)) begin
                    errors++;
                    $display("FAIL single_count: count=%0d, required 1", o_cnt);
                end
            end
            if (c < 4) begin
                checks++;
                if (o_mv !== 1'b0) begin
                    errors++;
                    $display("FAIL single_early_valid: cycle %0d m_valid=%b, required 0", c, o_mv);
                end
            end else begin
                checks++;
                if (o_mv !== 1'b1 || o_md !== 8'hA5) begin
                    errors++;
                    $display("FAIL single_latency: cycle 4 m_valid=%b m_data=%h, required 1 a5",
                             o_mv, o_md);
                end
            end
        end
        do_cycle(1'b0, '0, 1'b1);
        checks++;
        if (o_cnt !== '0 || o_mv !== 1'b0) begin
            errors++;
            $display("FAIL single_empty: count=%0d m_valid=%b, required 0 0", o_cnt, o_mv);
        end
    endtask

    task automatic test_fill;
        for (int i = 0; i < DEPTH; i++) begin
            do_cycle(1'b1, 8'(i), 1'b0);
            checks++;
            if (!o_acc) begin
                errors++;
                $display("FAIL fill_accept: word %0d s_ready=%b, required 1", i, o_sr);
            end
            checks++;
            if (o_exp_wptr % 2 == 0) begin
                if (o_b0we !== 1'b1 || o_b1we !== 1'b0 || o_b0a !== AW'(o_exp_wptr >> 1) || o_b0d !== 8'(i)) begin
                    errors++;
                    $display("FAIL fill_bank0: word %0d we=%b/%b addr=%0d din=%h, required 1/0 %0d %h",
                             i, o_b0we, o_b1we, o_b0a, o_b0d, o_exp_wptr >> 1, 8'(i));
                end
            end else begin
                if (o_b1we !== 1'b1 || o_b0we !== 1'b0 || o_b1a !== AW'(o_exp_wptr >> 1) || o_b1d !== 8'(i)) begin
                    errors++;
                    $display("FAIL fill_bank1: word %0d we=%b/%b addr=%0d din=%h, required 0/1 %0d %h",
                             i, o_b0we, o_b1we, o_b1a, o_b1d, o_exp_wptr >> 1, 8'(i));
                end
            end
        end
        do_cycle(1'b1, 8'hEE, 1'b0);
        checks++;
        if (o_sr !== 1'b0 || o_cnt !== CW'(DEPTH) || o_b0we !== 1'b0 || o_b1we !== 1'b0) begin
            errors++;
            $display("FAIL full: s_ready=%b count=%0d wr_en=%b%b, required 0 %0d 00",
                     o_sr, o_cnt, o_b0we, o_b1we, DEPTH);
        end
        for (int n = 0; n < 3000 && sb_q.size() > 0; n++) begin
            do_cycle(1'b0, '0, 1'b1);
            if (o_pop) begin
                checks++;
                if (o_md !== o_exp_md) begin
                    errors++;
                    $display("FAIL fill_drain_data: got %h, required %h", o_md, o_exp_md);
                end
            end
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL fill_drain_timeout: %0d words left, required 0", sb_q.size());
        end
    endtask

    task automatic test_stream;
        for (int c = 0; c < 2010; c++) begin
            do_cycle(c < 2000, 8'($urandom), 1'b1);
            if (o_pop) begin
                checks++;
                if (o_md !== o_exp_md) begin
                    errors++;
                    $display("FAIL stream_data: cycle %0d got %h, required %h", c, o_md, o_exp_md);
                end
            end
            if (c >= 4 && c < 2004) begin
                checks++;
                if (o_mv !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_gap: cycle %0d m_valid=%b, required 1", c, o_mv);
                end
            end
            if (c >= 4 && c < 2000) begin
                checks++;
                if (o_cnt !== CW'(4)) begin
                    errors++;
                    $display("FAIL stream_count: cycle %0d count=%0d, required 4", c, o_cnt);
                end
            end
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL stream_leftover: %0d words left, required 0", sb_q.size());
        end
    endtask

    task automatic test_random;
        int written = 0;
        logic sv;
        for (int n = 0; n < 30000 && (written < 3 * DEPTH || sb_q.size() > 0); n++) begin
            sv = (written < 3 * DEPTH) ? 1'($urandom % 2) : 1'b0;
            do_cycle(sv, 8'($urandom), (written < 3 * DEPTH) ? 1'($urandom % 2) : 1'b1);
            if (o_acc) written++;
            checks++;
            if (o_cnt !== CW'(o_exp_cnt) || o_sr !== (o_exp_cnt < DEPTH)) begin
                errors++;
                $display("FAIL random_count: count=%0d s_ready=%b, required %0d %b",
                         o_cnt, o_sr, o_exp_cnt, o_exp_cnt < DEPTH);
            end
            if (o_exp_cnt == 0) begin
                checks++;
                if (o_mv !== 1'b0) begin
                    errors++;
                    $display("FAIL random_empty_valid: m_valid=%b, required 0", o_mv);
                end
            end
            if (o_pop) begin
                checks++;
                if (o_md !== o_exp_md) begin
                    errors++;
                    $display("FAIL random_data: got %h, required %h", o_md, o_exp_md);
                end
            end
        end
        checks++;
        if (sb_q.size() != 0 || written < 3 * DEPTH) begin
            errors++;
            $display("FAIL random_timeout: written %0d left %0d, required %0d 0",
                     written, sb_q.size(), 3 * DEPTH);
        end
    endtask

    task automatic test_outbuf;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] first;
        first = 8'($urandom);
        for (int i = 0; i < 8; i++) do_cycle(1'b1, (i == 0) ? first : 8'($urandom), 1'b0);
        do_cycle(1'b0, '0, 1'b0);
        a0 = o_b0a;
        a1 = o_b1a;
        for (int i = 0; i < 10; i++) begin
            do_cycle(1'b0, '0, 1'b0);
            checks++;
            if (o_b0a !== a0 || o_b1a !== a1 || o_b0we !== 1'b0 || o_b1we !== 1'b0) begin
                errors++;
                $display("FAIL outbuf_no_read: addr %0d/%0d we %b%b, required %0d/%0d 00",
                         o_b0a, o_b1a, o_b0we, o_b1we, a0, a1);
            end
        end
        checks++;
        if (o_mv !== 1'b1 || o_md !== first || o_cnt !== CW'(8)) begin
            errors++;
            $display("FAIL outbuf_hold: m_valid=%b m_data=%h count=%0d, required 1 %h 8",
                     o_mv, o_md, o_cnt, first);
        end
        for (int n = 0; n < 40 && sb_q.size() > 0; n++) begin
            do_cycle(1'b0, '0, 1'b1);
            if (o_pop) begin
                checks++;
                if (o_md !== o_exp_md) begin
                    errors++;
                    $display("FAIL outbuf_drain_data: got %h, required %h", o_md, o_exp_md);
                end
            end
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL outbuf_drain_timeout: %0d words left, required 0", sb_q.size());
        end
    endtask

    task automatic test_reset_mid;
        bit got;
        for (int i = 0; i < 10; i++) do_cycle(1'b1, 8'($urandom), 1'b0);
        do_cycle(1'b0, '0, 1'b1);
        do_cycle(1'b0, '0, 1'b1);
        do_cycle(1'b0, '0, 1'b0);
        rstn = 1'b0;
        #1;
        checks++;
        if (bus.m_valid !== 1'b0 || bus.count !== '0 || bus.s_ready !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: m_valid=%b count=%0d s_ready=%b, required 0 0 0",
                     bus.m_valid, bus.count, bus.s_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        sb_q.delete();
        exp_cnt  = 0;
        exp_wptr = 0;
        do_cycle(1'b1, 8'h3C, 1'b1);
        checks++;
        if (o_b0we !== 1'b1 || o_b0a !== '0 || o_b0d !== 8'h3C) begin
            errors++;
            $display("FAIL midreset_write: b0we=%b addr=%0d din=%h, required 1 0 3c",
                     o_b0we, o_b0a, o_b0d);
        end
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            do_cycle(1'b0, '0, 1'b1);
            if (o_pop) begin
                got = 1'b1;
                checks++;
                if (o_md !== 8'h3C) begin
                    errors++;
                    $display("FAIL midreset_first: got %h, required 3c", o_md);
                end
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL midreset_timeout: no output within 20 cycles");
        end
        do_cycle(1'b0, '0, 1'b1);
        checks++;
        if (o_mv !== 1'b0 || o_cnt !== '0) begin
            errors++;
            $display("FAIL midreset_stale: m_valid=%b count=%0d, required 0 0", o_mv, o_cnt);
        end
    endtask

    initial begin
        rstn        = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;
        test_reset();
        test_single();
        test_fill();
        test_stream();
        test_random();
        test_outbuf();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
